// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder: a valid/ready beat in
// (a, b, cin, sub) and a valid/ready beat out (sum, cout, ovf).
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined carry-chain adder/subtractor: WIDTH bits split into STAGES segments,
// carry registered between stages. Define ADDER_SAT_EN for signed saturation.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;

  // Stage registers. a_q/b_q carry the operands forward so each stage finds its
  // segment still aligned; s_q accumulates finished lower result segments.
  word_t [STAGES-1:0] a_q, b_q, s_q;
  logic  [STAGES-1:0] c_q, v_q;
  logic               ovf_q;

  // Per-stage inputs (from ports for stage 0, from the previous stage otherwise).
  word_t [STAGES-1:0] a_i, b_i, s_i, s_n;
  logic  [STAGES-1:0] c_i, v_i, c_n;
  logic  [STAGES-1:0][SEG:0] seg_r;
  logic               msb_cin, ovf_n;
  word_t              sum_n;

  logic stall, advance;

  assign stall        = v_q[LAST] & ~bus.out_ready;
  assign advance      = ~stall;
  assign bus.in_ready = advance;

  // NOTE: every signal driven from an always_comb is assigned on every pass
  // through the block, so no latches are inferred.
  always_comb begin
    a_i[0] = bus.a;
    b_i[0] = bus.sub ? ~bus.b : bus.b;
    c_i[0] = bus.sub | bus.cin;
    s_i[0] = '0;
    v_i[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      c_i[k] = c_q[k-1];
      s_i[k] = s_q[k-1];
      v_i[k] = v_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_r[k] = {1'b0, a_i[k][k*SEG +: SEG]} + {1'b0, b_i[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, c_i[k]};
      s_n[k]   = s_i[k] | (word_t'(seg_r[k][SEG-1:0]) << (k * SEG));
      c_n[k]   = seg_r[k][SEG];
    end
    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
    msb_cin = a_i[LAST][WIDTH-1] ^ b_i[LAST][WIDTH-1] ^ s_n[LAST][WIDTH-1];
    ovf_n   = msb_cin ^ c_n[LAST];
    sum_n   = s_n[LAST];
`ifdef ADDER_SAT_EN
    if (ovf_n) begin
      sum_n = a_i[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every stage
  // samples the previous stage's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset as well as the valid bits, so the
      // result outputs read 0 during reset and never carry X afterwards.
      v_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      v_q <= v_i;
      a_q <= a_i;
      b_q <= b_i;
      for (int k = 0; k < LAST; k++) begin
        s_q[k] <= s_n[k];
        c_q[k] <= c_n[k];
      end
      // Result registers only load real beats; bubbles leave the last result.
      if (v_i[LAST]) begin
        s_q[LAST] <= sum_n;
        c_q[LAST] <= c_n[LAST];
        ovf_q     <= ovf_n;
      end
    end
  end

  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = ovf_q;

  // Operand copies in the final stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[LAST], b_q[LAST]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=16, STAGES=4);
// expected results follow ADDER_SAT_EN when it is defined.
module tb_pipelined_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

`ifdef ADDER_SAT_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h8000;
  localparam logic [15:0] EXP_NEG_OVF = 16'h7FFF;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // Send one beat into an empty pipeline and check out_valid on each of the
  // following cycles, plus the result fields on the cycle it appears.
  task automatic send_one(input string name, input logic [15:0] op_a, op_b,
                          input logic op_cin, op_sub, input logic [15:0] exp_sum,
                          input logic exp_cout, exp_ovf);
    @(negedge clk);
    bus.a = op_a; bus.b = op_b; bus.cin = op_cin; bus.sub = op_sub;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc <= STAGES; cyc++) begin
      if (cyc > 0) @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'(cyc == STAGES - 1)) begin
        tests_failed++;
        $display("FAIL %s_valid cycle %0d: got %b want %b", name, cyc, bus.out_valid,
                 1'(cyc == STAGES - 1));
      end
      if (cyc == STAGES - 1) begin
        tests_run++;
        if (bus.sum !== exp_sum) begin
          tests_failed++;
          $display("FAIL %s_sum: got %h want %h", name, bus.sum, exp_sum);
        end
        tests_run++;
        if (bus.cout !== exp_cout) begin
          tests_failed++;
          $display("FAIL %s_cout: got %b want %b", name, bus.cout, exp_cout);
        end
        tests_run++;
        if (bus.ovf !== exp_ovf) begin
          tests_failed++;
          $display("FAIL %s_ovf: got %b want %b", name, bus.ovf, exp_ovf);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    tests_run++;
    if (bus.sum !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_sum: got %h want 0000", bus.sum);
    end
    tests_run++;
    if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: got cout=%b ovf=%b want 0 0", bus.cout, bus.ovf);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_one("add_basic", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
  endtask

  task automatic test_carry_chain();
    send_one("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("carry_cin", 16'hFFFE, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    send_one("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, EXP_POS_OVF, 1'b0, 1'b1);
    send_one("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, EXP_NEG_OVF, 1'b1, 1'b1);
  endtask

  task automatic test_subtract();
    send_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_one("sub_plain",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    int          beat       = 0;
    int          stall_left = 0;
    int          low_cycles = 0;
    bit          dropped    = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 60 && got.size() < 8; cyc++) begin
      if (bus.out_valid && !dropped) begin
        dropped    = 1'b1;
        stall_left = 3;
      end
      bus.out_ready = (stall_left == 0);
      if (stall_left > 0) begin
        stall_left--;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0100) begin
          tests_failed++;
          $display("FAIL bp_hold: got valid=%b sum=%h want 1 0100", bus.out_valid, bus.sum);
        end
      end
      bus.in_valid = (beat < 8);
      bus.a        = beat[15:0];
      bus.b        = 16'h0100;
      bus.cin      = 1'b0;
      bus.sub      = 1'b0;
      #1;
      if (!bus.in_ready) low_cycles++;
      if (bus.in_valid && bus.in_ready) beat++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.sum);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tests_run++;
    if (got.size() != 8) begin
      tests_failed++; $display("FAIL bp_count: got %0d results want 8", got.size());
    end
    tests_run++;
    if (low_cycles != 3) begin
      tests_failed++; $display("FAIL bp_in_ready_low: got %0d cycles want 3", low_cycles);
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      tests_run++;
      if (got[i] !== 16'h0100 + 16'(i)) begin
        tests_failed++;
        $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 16'h0100 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.a = 16'h0010 + 16'(i); bus.b = 16'h0001; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0011) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got valid=%b sum=%h want 1 0011", bus.out_valid, bus.sum);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid);
    end
    tests_run++;
    if (bus.sum !== 16'h0000) begin
      tests_failed++; $display("FAIL rst_mid_sum: got %h want 0000", bus.sum);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    send_one("rst_recover", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined carry-chain adder/subtractor and successor to the fixed 16-bit ripple adder used in the FMAC datapath.
- The WIDTH-bit operation is split into STAGES equal segments, one segment per stage, with the carry registered between stages.
- Sustains one operation per cycle at a higher clock rate.
- Valid/ready handshakes on both sides, so it can sit between the multiplier array and the accumulator register with backpressure.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and carry segments; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; in sub mode it is ignored and forced to 1.
- sub  input  1  0: A+B+cin; 1: A-B (computed as A + ~B + 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; in sub mode 1 means no borrow (A >= B unsigned).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high. While rst is high:
  - every stage valid bit is cleared;
  - out_valid=0, sum=0, cout=0, ovf=0;
  - in_ready=1.
- Reset mid-operation: all in-flight beats are discarded, no partial output appears, and the first beat accepted after release flows normally.
- Segment width is SEG = WIDTH/STAGES. Stage k (0..STAGES-1):
  - adds segment k of A and of the B operand (B or ~B), plus the carry registered by stage k-1;
  - stage 0 uses cin, or 1 in sub mode.
- Skew handling:
  - upper operand segments are delay-registered until their stage is reached;
  - lower result segments are delay-registered so that all result bits of one beat leave together.
- Latency:
  - a beat accepted at edge N appears at the outputs after edge N+STAGES-1 (out_valid high from then on);
  - STAGES=1 gives a registered single-cycle adder.
- Throughput: one beat per cycle while unstalled; results leave in acceptance order.
- Handshake:
  - stall = out_valid & ~out_ready;
  - in_ready = ~stall;
  - a beat transfers on in_valid & in_ready;
  - the whole pipeline, including data and valid bits, holds while stall is high;
  - bubbles are not compressed;
  - sum, cout and ovf are stable while out_valid=1 and out_ready=0.
- Empty stages: when in_valid=0 while unstalled, a bubble (valid=0) enters stage 0.
- Simultaneous accept and retire in the same cycle is allowed, with no loss.
- cout is the carry out of the MSB of the final stage.
- ovf = carry into MSB XOR carry out of MSB; computed in the last stage.
- Don't-care rule: sum, cout and ovf are don't-care when out_valid=0, but must hold their last value (no X propagation after reset).

Optional Feature:
- Macro ADDER_SAT_EN.
- Defined (signed saturation):
  - when ovf=1, sum is forced to the signed maximum (0 followed by all 1s) if a's MSB is 0, otherwise to the signed minimum (1 followed by all 0s);
  - a's MSB is carried through the pipeline for this purpose;
  - ovf is still reported as 1 and cout is unchanged;
  - latency is unchanged.
- Undefined: two's-complement wrap-around; no extra logic.

Test Plan:
- WIDTH=16, STAGES=4; a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later: sum=0x0100, cout=0, ovf=0, out_valid high for exactly 1 cycle.
- a=0xFFFF, b=0x0001, cin=0 (carry through all four segments) -> sum=0x0000, cout=1, ovf=0; then a=0xFFFE, b=0x0000, cin=1 -> sum=0xFFFF, cout=0.
- a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1 (with ADDER_SAT_EN: sum=0x7FFF, ovf=1); a=0x8000, b=0x0001, sub -> sum=0x7FFF, ovf=1 (with ADDER_SAT_EN: 0x8000).
- sub=1, a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored); a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
- Backpressure: stream 8 back-to-back beats (a=i, b=0x0100, i=0..7); drop out_ready for 3 cycles once out_valid rises -> in_ready low for exactly those 3 cycles, all 8 results 0x0100+i appear in order, none lost or duplicated.
- Reset mid-stream: 3 beats in flight, pulse rst asynchronously between edges -> out_valid=0 and sum=0 immediately; a new beat after release (0x1234+0x0001) -> sum=0x1235, 4 cycles later.
